pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Instruction-sequencing controller for the program counter. It owns the PC register, paces fetches against a multi-cycle instruction ROM, and resolves next-PC selection each instruction: sequential, jump, call, return or interrupt entry. It sits between the instruction ROM address port and the decoder, and replaces free-running per-clock PC increment with a fetch/exec state machine and a hardware return-address stack.

## Interface
- PC_W, 11, PC and address width
- STACK_DEPTH, 4, return-address stack entries (≥1)
- ROM_WAIT, 1, ROM wait cycles per fetch (0..15)
- IRQ_VECTOR, 11'h7F0, interrupt entry address
- clk  in  1  clock, all state on rising edge
- nreset  in  1  asynchronous, active-low reset
- type_i  in  7  decoded instruction type; bit 6 = PC-class instruction
- cond_i  in  1  branch condition (flag/B1 result)
- target_i  in  PC_W  jump/call target
- call_i  in  1  PC-class instruction is a call
- ret_i  in  1  PC-class instruction is a return
- stall_i  in  1  hold current instruction in EXEC
- irq_i  in  1  level interrupt request
- pc_o  out  PC_W  ROM address / current PC
- instr_valid_o  out  1  ROM data valid, decoder inputs sampled this cycle
- irq_ack_o  out  1  one-cycle interrupt-taken pulse
- stack_err_o  out  1  sticky overflow/underflow flag

## Operation
- States: FETCH → WAIT (ROM_WAIT cycles, skipped when 0) → EXEC → FETCH. Reset state FETCH.
- Reset values: pc_o=0, instr_valid_o=0, irq_ack_o=0, stack_err_o=0, stack empty, interrupt-enable ie=1.
- instr_valid_o=1 exactly while in EXEC. pc_o is constant from FETCH through EXEC.
- EXEC with stall_i=1: remain in EXEC, no PC or stack change.
- EXEC without stall: next PC is chosen by the first matching rule, in this order:
  1. irq_i & ie & stack not full: push PC+1; PC=IRQ_VECTOR; ie=0; irq_ack_o pulses in the following FETCH cycle.
  2. type_i[6] & cond_i & ret_i: pop into PC; ie=1. If the stack is empty: PC=PC+1 and stack_err_o=1.
  3. type_i[6] & cond_i & call_i: push PC+1; PC=target_i. If the stack is full: push dropped, jump still taken, stack_err_o=1.
  4. type_i[6] & cond_i: PC=target_i.
  5. Otherwise: PC=PC+1.
- PC arithmetic is modulo 2^PC_W: PC 2^PC_W−1 increments to 0. A pushed return address wraps the same way.
- An interrupt with the stack full is deferred, not dropped. It is taken at the first EXEC with a free slot.
- stack_err_o clears only on reset.
- nreset low mid-instruction aborts immediately to reset values. No push or pop in progress survives.

## Timing
- Edge 1 is the first rising edge after nreset deasserts. The instruction period is ROM_WAIT+2 cycles.
- With ROM_WAIT=1, instr_valid_o is high in cycle 3, and the next pc_o appears after edge 3.
- Each stall cycle extends EXEC by exactly one cycle.
- Decoder inputs are sampled only on the edge leaving EXEC. They are don't-care otherwise.
- Stack push/pop and PC update occur on the same edge. Ret-after-call needs no bubble.

## Configuration
- PC_SEQ_IRQ_EN defined: irq_i, ie and rule 1 active as above.
- PC_SEQ_IRQ_EN undefined: irq_i ignored, irq_ack_o tied 0, ie logic removed, return does not touch ie.

## Structure
- Package ev22_seq_pkg holds: state enum (FETCH, WAIT, EXEC), TYPE_PC_BIT=6, default PC_W and IRQ_VECTOR.
- Sub-module return_stack: parameterised LIFO (width PC_W, depth STACK_DEPTH) with push/pop/full/empty and a same-cycle data-out. Sequencer FSM and next-PC mux stay in pc_sequencer.

## Test plan
- Reset then 4 sequential instructions (ROM_WAIT=1) → pc_o 0,1,2,3 held 3 cycles each; instr_valid_o high in the third cycle of each.
- type_i[6]=1, cond_i=1, target_i=0x120 at PC 5 → next pc_o 0x120. Same with cond_i=0 → next pc_o 6.
- Call at PC 0x10 to 0x200, then ret → pc_o 0x200, then 0x11. Five nested calls (STACK_DEPTH=4) → fifth jump taken, stack_err_o=1.
- Ret with empty stack at PC 7 → pc_o 8, stack_err_o=1. It stays 1 until nreset.
- PC_SEQ_IRQ_EN: irq_i=1 during EXEC at PC 0x30 → pc_o 0x7F0 and irq_ack_o pulse. A second irq is ignored until ret, which returns to 0x31.
- stall_i high 3 cycles in EXEC at PC 9 → EXEC lasts 4 cycles, pc_o stays 9. nreset pulsed mid-WAIT → pc_o 0 and state FETCH.

Source files
------------

// File: rtl/ev22_seq_pkg.sv
// rtl/ev22_seq_pkg.sv - shared types and defaults for the program-counter sequencer
package ev22_seq_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      EXEC  = 2'd2
   } seq_state_t;

   localparam int          TYPE_PC_BIT    = 6;
   localparam int          DEF_PC_W       = 11;
   localparam logic [10:0] DEF_IRQ_VECTOR = 11'h7F0;

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - hardware return-address LIFO with same-cycle top-of-stack output
module return_stack #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
)(
   input  logic             clk,
   input  logic             nreset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    count;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Top entry sits at index count-1; a loop avoids an oversized array index.
   always_comb begin
      dout = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (count == CW'(i + 1)) dout = mem[i];
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !full) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (count == CW'(i)) mem[i] <= din;
         end
         count <= count + 1'b1;
      end else if (pop && !empty) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/exec PC sequencer with return stack; PC_SEQ_IRQ_EN enables interrupt entry
module pc_sequencer
   import ev22_seq_pkg::*;
#(
   parameter int              PC_W        = DEF_PC_W,
   parameter int              STACK_DEPTH = 4,
   parameter int              ROM_WAIT    = 1,
   parameter logic [PC_W-1:0] IRQ_VECTOR  = PC_W'(DEF_IRQ_VECTOR)
)(
   input  logic            clk,
   input  logic            nreset,
   input  logic [6:0]      type_i,
   input  logic            cond_i,
   input  logic [PC_W-1:0] target_i,
   input  logic            call_i,
   input  logic            ret_i,
   input  logic            stall_i,
   input  logic            irq_i,
   output logic [PC_W-1:0] pc_o,
   output logic            instr_valid_o,
   output logic            irq_ack_o,
   output logic            stack_err_o
);

   seq_state_t      state;
   logic [3:0]      wait_cnt;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] stack_top;
   logic            stack_full;
   logic            stack_empty;
   logic            leave_exec;
   logic            pc_class;
   logic            irq_take;
   logic            push_req;
   logic            pop_req;
   logic            err_set;
   logic            stack_err;
   logic            unused_type;

   assign pc_inc        = pc + 1'b1;
   assign leave_exec    = (state == EXEC) && !stall_i;
   assign pc_class      = type_i[TYPE_PC_BIT] & cond_i;
   assign unused_type   = ^type_i[TYPE_PC_BIT-1:0];
   assign pc_o          = pc;
   assign instr_valid_o = (state == EXEC);
   assign stack_err_o   = stack_err;

`ifdef PC_SEQ_IRQ_EN
   logic ie;
   logic irq_ack;

   // A full stack defers the interrupt; the level request keeps it pending.
   assign irq_take  = irq_i & ie & ~stack_full;
   assign irq_ack_o = irq_ack;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         ie      <= 1'b1;
         irq_ack <= 1'b0;
      end else begin
         irq_ack <= leave_exec & irq_take;
         if (leave_exec) begin
            if (irq_take)               ie <= 1'b0;
            else if (pc_class && ret_i) ie <= 1'b1;
         end
      end
   end
`else
   logic unused_irq;

   assign unused_irq = irq_i;
   assign irq_take   = 1'b0;
   assign irq_ack_o  = 1'b0;
`endif

   // Next-PC priority: interrupt, return, call, jump, sequential.
   always_comb begin
      push_req = 1'b0;
      pop_req  = 1'b0;
      err_set  = 1'b0;
      pc_next  = pc_inc;
      if (irq_take) begin
         push_req = 1'b1;
         pc_next  = IRQ_VECTOR;
      end else if (pc_class && ret_i) begin
         if (stack_empty) begin
            err_set = 1'b1;
         end else begin
            pop_req = 1'b1;
            pc_next = stack_top;
         end
      end else if (pc_class && call_i) begin
         if (stack_full) err_set  = 1'b1;
         else            push_req = 1'b1;
         pc_next = target_i;
      end else if (pc_class) begin
         pc_next = target_i;
      end
   end

   return_stack #(
      .WIDTH (PC_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk    (clk),
      .nreset (nreset),
      .push   (leave_exec & push_req),
      .pop    (leave_exec & pop_req),
      .din    (pc_inc),
      .dout   (stack_top),
      .full   (stack_full),
      .empty  (stack_empty)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= FETCH;
         wait_cnt  <= '0;
         pc        <= '0;
         stack_err <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (ROM_WAIT == 0) begin
                  state <= EXEC;
               end else begin
                  state    <= WAIT;
                  wait_cnt <= 4'(ROM_WAIT - 1);
               end
            end
            WAIT: begin
               if (wait_cnt == '0) state <= EXEC;
               else                wait_cnt <= wait_cnt - 1'b1;
            end
            EXEC: begin
               if (!stall_i) begin
                  state <= FETCH;
                  pc    <= pc_next;
                  if (err_set) stack_err <= 1'b1;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer; interrupt cases under PC_SEQ_IRQ_EN
module tb_pc_sequencer;

   typedef struct {
      logic [10:0] pc;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic [6:0]  type_i = '0;
   logic        cond_i = 1'b0;
   logic [10:0] target_i = '0;
   logic        call_i = 1'b0;
   logic        ret_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        irq_i = 1'b0;
   logic [10:0] pc_o;
   logic        instr_valid_o;
   logic        irq_ack_o;
   logic        stack_err_o;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fails = 0;

   pc_sequencer #(
      .PC_W        (11),
      .STACK_DEPTH (4),
      .ROM_WAIT    (1),
      .IRQ_VECTOR  (11'h7F0)
   ) dut (
      .clk           (clk),
      .nreset        (nreset),
      .type_i        (type_i),
      .cond_i        (cond_i),
      .target_i      (target_i),
      .call_i        (call_i),
      .ret_i         (ret_i),
      .stall_i       (stall_i),
      .irq_i         (irq_i),
      .pc_o          (pc_o),
      .instr_valid_o (instr_valid_o),
      .irq_ack_o     (irq_ack_o),
      .stack_err_o   (stack_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Decoder inputs are don't-care outside the EXEC exit edge, so scramble them.
   task automatic junk_inputs();
      type_i   = 7'($urandom);
      cond_i   = 1'($urandom);
      target_i = 11'($urandom);
      call_i   = 1'($urandom);
      ret_i    = 1'($urandom);
      stall_i  = 1'($urandom);
      irq_i    = 1'($urandom);
   endtask

   task automatic wait_exec(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (instr_valid_o) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("exec_timeout", 32'(instr_valid_o), 32'd1);
   endtask

   task automatic exec_instr(input logic pcls, input logic c, input logic [10:0] tgt,
                             input logic cl, input logic rt, input logic irq,
                             input logic [10:0] exp_pc, input logic exp_err);
      bit   ok;
      exp_t e;
      wait_exec(ok);
      type_i   = pcls ? (7'h40 | 7'($urandom_range(0, 63))) : 7'($urandom_range(0, 63));
      cond_i   = c;
      target_i = tgt;
      call_i   = cl;
      ret_i    = rt;
      stall_i  = 1'b0;
      irq_i    = irq;
      @(posedge clk);
      #1;
      junk_inputs();
      e.pc  = exp_pc;
      e.err = exp_err;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      exp_t e;
      nreset = 1'b0;
      #1;
      check("rst_pc", 32'(pc_o), 32'd0);
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      check("rst_ack", 32'(irq_ack_o), 32'd0);
      check("rst_err", 32'(stack_err_o), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      nreset = 1'b1;
      exp_q.delete();
      e.pc  = '0;
      e.err = 1'b0;
      exp_q.push_back(e);
      check("t_cycle1_valid", 32'(instr_valid_o), 32'd0);
      @(negedge clk);
      check("t_cycle2_valid", 32'(instr_valid_o), 32'd0);
      @(negedge clk);
      check("t_cycle3_valid", 32'(instr_valid_o), 32'd1);
   endtask

   // Monitor: every new EXEC presents one instruction; compare against the scoreboard.
   initial begin
      logic prev_valid;
      exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (nreset && instr_valid_o && !prev_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_exec", 32'(pc_o), 32'h7FFFFFFF);
            end else begin
               e = exp_q.pop_front();
               check("exec_pc", 32'(pc_o), 32'(e.pc));
               check("exec_err", 32'(stack_err_o), 32'(e.err));
            end
         end
         prev_valid = nreset && instr_valid_o;
      end
   end

   initial begin
      bit ok;
      junk_inputs();
      do_reset();

      // Sequential, jump taken / not taken, empty return, stall.
      exec_instr(0, 0, 11'h000, 0, 0, 0, 11'h001, 0);
      exec_instr(0, 0, 11'h000, 0, 0, 0, 11'h002, 0);
      exec_instr(0, 0, 11'h000, 0, 0, 0, 11'h003, 0);
      exec_instr(0, 0, 11'h000, 0, 0, 0, 11'h004, 0);
      exec_instr(0, 1, 11'h100, 0, 0, 0, 11'h005, 0);
      exec_instr(1, 1, 11'h120, 0, 0, 0, 11'h120, 0);
      exec_instr(1, 1, 11'h005, 0, 0, 0, 11'h005, 0);
      exec_instr(1, 0, 11'h120, 0, 0, 0, 11'h006, 0);
      exec_instr(0, 0, 11'h000, 0, 0, 0, 11'h007, 0);
      exec_instr(1, 1, 11'h3AA, 0, 1, 0, 11'h008, 1);
      exec_instr(0, 0, 11'h000, 0, 0, 0, 11'h009, 1);

      wait_exec(ok);
      type_i  = 7'h00;
      stall_i = 1'b1;
      irq_i   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("stall_pc", 32'(pc_o), 32'h009);
         check("stall_valid", 32'(instr_valid_o), 32'd1);
      end
      stall_i = 1'b0;
      @(posedge clk);
      #1;
      check("stall_exit_valid", 32'(instr_valid_o), 32'd0);
      exp_q.push_back('{11'h00A, 1'b1});
      junk_inputs();

      // PC and pushed return address both wrap at 2^11.
      exec_instr(1, 1, 11'h7FF, 0, 0, 0, 11'h7FF, 1);
      exec_instr(1, 1, 11'h050, 1, 0, 0, 11'h050, 1);
      exec_instr(1, 1, 11'h123, 0, 1, 0, 11'h000, 1);

      // Reset during WAIT aborts back to PC 0 and clears the sticky error.
      exec_instr(0, 0, 11'h000, 0, 0, 0, 11'h001, 1);
      @(posedge clk);
      #1;
      check("midwait_valid", 32'(instr_valid_o), 32'd0);
      check("midwait_pc", 32'(pc_o), 32'h001);
      do_reset();

      // Call/return and stack overflow.
      exec_instr(1, 1, 11'h010, 0, 0, 0, 11'h010, 0);
      exec_instr(1, 1, 11'h200, 1, 0, 0, 11'h200, 0);
      exec_instr(1, 1, 11'h000, 0, 1, 0, 11'h011, 0);
      exec_instr(1, 1, 11'h300, 1, 0, 0, 11'h300, 0);
      exec_instr(1, 1, 11'h310, 1, 0, 0, 11'h310, 0);
      exec_instr(1, 1, 11'h320, 1, 0, 0, 11'h320, 0);
      exec_instr(1, 1, 11'h330, 1, 0, 0, 11'h330, 0);
      exec_instr(1, 1, 11'h340, 1, 0, 0, 11'h340, 1);
      exec_instr(1, 1, 11'h000, 0, 1, 0, 11'h321, 1);
      exec_instr(1, 1, 11'h000, 0, 1, 0, 11'h311, 1);
      exec_instr(1, 1, 11'h000, 0, 1, 0, 11'h301, 1);
      exec_instr(1, 1, 11'h000, 0, 1, 0, 11'h012, 1);

`ifdef PC_SEQ_IRQ_EN
      do_reset();
      exec_instr(1, 1, 11'h030, 0, 0, 0, 11'h030, 0);
      exec_instr(0, 0, 11'h000, 0, 0, 1, 11'h7F0, 0);
      check("irq_ack_pulse", 32'(irq_ack_o), 32'd1);
      @(posedge clk);
      #1;
      check("irq_ack_clear", 32'(irq_ack_o), 32'd0);
      exec_instr(0, 0, 11'h000, 0, 0, 1, 11'h7F1, 0);
      check("irq_masked_ack", 32'(irq_ack_o), 32'd0);
      exec_instr(1, 1, 11'h000, 0, 1, 1, 11'h031, 0);
      check("irq_ret_ack", 32'(irq_ack_o), 32'd0);
      exec_instr(0, 0, 11'h000, 0, 0, 1, 11'h7F0, 0);
      check("irq_reenable_ack", 32'(irq_ack_o), 32'd1);
      exec_instr(1, 1, 11'h000, 0, 1, 0, 11'h032, 0);
`endif

      wait_exec(ok);
      @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
